fetch_unit: RTL and testbench

Instruction-fetch stage for the THOR_V2 core. It owns the PC, queries the branch predictor with the current PC, issues word requests to instruction memory and buffers returned instructions with their prediction metadata in a small queue for decode. It sits directly upstream of the BPU, supplying its lookup address and consuming its prediction. It sits directly upstream of decode, which consumes its queue. Execute-stage redirects flush it.

---
 rtl/thor_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/thor_pkg.sv
// Shared types and constants for the THOR_V2 fetch slice.
// Fetch queue entries carry the instruction plus the prediction made when it was issued.
package thor_pkg;

  localparam int XLEN   = 32;
  localparam int PIDX_W = 6;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc;
    logic              predTaken;
    logic [XLEN-1:0]   predTarget;
    logic [PIDX_W-1:0] predIndex;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of BPU, instruction-memory, redirect and decode signals around the fetch unit.
// master is the fetch unit's view; slave is the surrounding core/memory view.
interface fetch_unit_if;
  import thor_pkg::*;

  logic              redirect;
  logic [XLEN-1:0]   redirectPc;
  logic [XLEN-1:0]   bpuAddr;
  logic              bpuTaken;
  logic [XLEN-1:0]   bpuTarget;
  logic [PIDX_W-1:0] bpuIndex;
  logic              imemReqValid;
  logic [XLEN-1:0]   imemReqAddr;
  logic              imemReqReady;
  logic              imemRespValid;
  logic [31:0]       imemRespData;
  logic              decValid;
  logic [31:0]       decInstr;
  logic [XLEN-1:0]   decPc;
  logic              decPredTaken;
  logic [XLEN-1:0]   decPredTarget;
  logic [PIDX_W-1:0] decPredIndex;
  logic              decReady;

  modport master (
    input  redirect, redirectPc, bpuTaken, bpuTarget, bpuIndex,
           imemReqReady, imemRespValid, imemRespData, decReady,
    output bpuAddr, imemReqValid, imemReqAddr,
           decValid, decInstr, decPc, decPredTaken, decPredTarget, decPredIndex
  );

  modport slave (
    output redirect, redirectPc, bpuTaken, bpuTarget, bpuIndex,
           imemReqReady, imemRespValid, imemRespData, decReady,
    input  bpuAddr, imemReqValid, imemReqAddr,
           decValid, decInstr, decPc, decPredTaken, decPredTarget, decPredIndex
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with clear; the head is read straight
// from registered storage so decode never sees a combinational path from memory.
module fetch_queue
  import thor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  output fetch_entry_t               head_o,
  output logic                       head_valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage, pointers and occupancy; storage is reset so decode outputs start at zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign head_valid_o = (count_q != '0);
  assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// THOR_V2 instruction fetch: owns the PC, issues one word request at a time,
// and queues returned instructions with the prediction captured at issue.
module fetch_unit
  import thor_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              FQ_DEPTH = 4
) (
  input logic          clock,
  input logic          resetn,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0]   pc_q,          pc_d;
  logic              outstanding_q, outstanding_d;
  logic              drop_q,        drop_d;
  logic [XLEN-1:0]   pend_pc_q,     pend_pc_d;
  logic              pend_taken_q,  pend_taken_d;
  logic [XLEN-1:0]   pend_target_q, pend_target_d;
  logic [PIDX_W-1:0] pend_index_q,  pend_index_d;

  logic             has_room_s;
  logic             can_issue_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             head_valid_s;
  logic [CNT_W-1:0] count_s;
  fetch_entry_t     head_s;
  fetch_entry_t     push_entry_s;

  // The in-flight request always owns a slot, even on the cycle its response lands,
  // so a response can never find the queue full.
  assign has_room_s  = (count_s + CNT_W'(outstanding_q)) < CNT_W'(FQ_DEPTH);
  assign can_issue_s = resetn && (!outstanding_q || bus.imemRespValid) && has_room_s && !bus.redirect;
  assign accept_s    = can_issue_s && bus.imemReqReady;
  assign push_s      = bus.imemRespValid && outstanding_q && !drop_q && !bus.redirect;
  assign pop_s       = head_valid_s && bus.decReady && !bus.redirect;

  // Queue entry assembled from the response word and the metadata held since issue.
  always_comb begin
    push_entry_s            = '0;
    push_entry_s.instr      = bus.imemRespData;
    push_entry_s.pc         = pend_pc_q;
    push_entry_s.predTaken  = pend_taken_q;
    push_entry_s.predTarget = pend_target_q;
    push_entry_s.predIndex  = pend_index_q;
  end

  // Next PC, request tracking and drop bookkeeping; redirect overrides everything.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    pend_pc_d     = pend_pc_q;
    pend_taken_d  = pend_taken_q;
    pend_target_d = pend_target_q;
    pend_index_d  = pend_index_q;
    if (bus.redirect) begin
      pc_d          = word_align(bus.redirectPc);
      outstanding_d = outstanding_q && !bus.imemRespValid;
      drop_d        = outstanding_q && !bus.imemRespValid;
    end else if (accept_s) begin
      pc_d          = bus.bpuTaken ? bus.bpuTarget : (pc_q + XLEN'(4));
      outstanding_d = 1'b1;
      drop_d        = 1'b0;
      pend_pc_d     = pc_q;
      pend_taken_d  = bus.bpuTaken;
      pend_target_d = bus.bpuTarget;
      pend_index_d  = bus.bpuIndex;
    end else if (bus.imemRespValid && outstanding_q) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end else begin
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      pend_pc_q     <= '0;
      pend_taken_q  <= 1'b0;
      pend_target_q <= '0;
      pend_index_q  <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      pend_pc_q     <= pend_pc_d;
      pend_taken_q  <= pend_taken_d;
      pend_target_q <= pend_target_d;
      pend_index_q  <= pend_index_d;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clock        (clock),
    .resetn       (resetn),
    .clear_i      (bus.redirect),
    .push_i       (push_s),
    .push_data_i  (push_entry_s),
    .pop_i        (pop_s),
    .head_o       (head_s),
    .head_valid_o (head_valid_s),
    .count_o      (count_s)
  );

  assign bus.bpuAddr       = pc_q;
  assign bus.imemReqValid  = can_issue_s;
  assign bus.imemReqAddr   = pc_q;
  assign bus.decValid      = head_valid_s;
  assign bus.decInstr      = head_s.instr;
  assign bus.decPc         = head_s.pc;
  assign bus.decPredTaken  = head_s.predTaken;
  assign bus.decPredTarget = head_s.predTarget;
  assign bus.decPredIndex  = head_s.predIndex;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a one-deep memory model, a fixed BPU that
// predicts 0x8 -> 0x40, and hand-computed expectations at each cycle.
module tb_fetch_unit;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic        mem_busy = 1'b0;
  logic        mem_hold = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  logic [31:0] exp_addr [7];

  fetch_unit_if bus ();

  fetch_unit u_dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive memory response and BPU answer for the cycle, then let outputs settle.
  task automatic begin_cycle();
    @(negedge clock);
    bus.imemRespValid = mem_busy && !mem_hold;
    bus.imemRespData  = (mem_busy && !mem_hold) ? instr_of(mem_addr) : 32'h0;
    bus.bpuTaken      = (bus.bpuAddr == 32'h0000_0008);
    bus.bpuTarget     = bus.bpuTaken ? 32'h0000_0040 : 32'h0;
    bus.bpuIndex      = bus.bpuAddr[7:2];
    #1;
  endtask

  // Record what the memory accepted this cycle, then cross the active edge.
  task automatic end_cycle();
    if (bus.imemReqValid && bus.imemReqReady) begin
      mem_busy = 1'b1;
      mem_addr = bus.imemReqAddr;
    end else if (bus.imemRespValid) begin
      mem_busy = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.redirect      = 1'b0;
    bus.redirectPc    = 32'h0;
    bus.bpuTaken      = 1'b0;
    bus.bpuTarget     = 32'h0;
    bus.bpuIndex      = 6'h0;
    bus.imemReqReady  = 1'b1;
    bus.imemRespValid = 1'b0;
    bus.imemRespData  = 32'h0;
    bus.decReady      = 1'b1;
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44, 32'h48, 32'h4C};

    // Reset state
    begin_cycle();
    check_eq("rst_req_valid", 64'(bus.imemReqValid), 64'd0);
    check_eq("rst_bpu_addr",  64'(bus.bpuAddr),      64'h0);
    check_eq("rst_req_addr",  64'(bus.imemReqAddr),  64'h0);
    check_eq("rst_dec_valid", 64'(bus.decValid),     64'd0);
    check_eq("rst_dec_instr", 64'(bus.decInstr),     64'h0);
    end_cycle();
    resetn = 1'b1;

    // Straight-line fetch with a taken prediction at 0x8
    for (int k = 0; k < 7; k++) begin
      begin_cycle();
      check_eq($sformatf("seq_req_valid[%0d]", k), 64'(bus.imemReqValid), 64'd1);
      check_eq($sformatf("seq_req_addr[%0d]", k),  64'(bus.imemReqAddr),  64'(exp_addr[k]));
      if (k < 2) begin
        check_eq($sformatf("seq_dec_valid[%0d]", k), 64'(bus.decValid), 64'd0);
      end else begin
        check_eq($sformatf("seq_dec_valid[%0d]", k), 64'(bus.decValid), 64'd1);
        check_eq($sformatf("seq_dec_pc[%0d]", k),    64'(bus.decPc),    64'(exp_addr[k-2]));
        check_eq($sformatf("seq_dec_instr[%0d]", k), 64'(bus.decInstr), 64'(instr_of(exp_addr[k-2])));
      end
      if (k == 3) begin
        check_eq("nt_pred_taken", 64'(bus.decPredTaken), 64'd0);
        check_eq("nt_pred_index", 64'(bus.decPredIndex), 64'h1);
      end
      if (k == 4) begin
        check_eq("tk_pred_taken",  64'(bus.decPredTaken),  64'd1);
        check_eq("tk_pred_target", 64'(bus.decPredTarget), 64'h40);
        check_eq("tk_pred_index",  64'(bus.decPredIndex),  64'h2);
      end
      end_cycle();
    end

    // Back-pressure: queue fills to four, issue stops, then resumes
    bus.decReady = 1'b0;
    begin_cycle();
    check_eq("bp0_req_valid", 64'(bus.imemReqValid), 64'd1);
    check_eq("bp0_req_addr",  64'(bus.imemReqAddr),  64'h50);
    end_cycle();
    begin_cycle();
    check_eq("bp1_req_valid", 64'(bus.imemReqValid), 64'd1);
    check_eq("bp1_req_addr",  64'(bus.imemReqAddr),  64'h54);
    end_cycle();
    begin_cycle();
    check_eq("bp2_req_valid", 64'(bus.imemReqValid), 64'd0);
    end_cycle();
    begin_cycle();
    check_eq("bp3_req_valid", 64'(bus.imemReqValid), 64'd0);
    check_eq("bp3_dec_pc",    64'(bus.decPc),        64'h48);
    end_cycle();
    bus.decReady = 1'b1;
    begin_cycle();
    check_eq("bp4_req_valid", 64'(bus.imemReqValid), 64'd0);
    check_eq("bp4_dec_pc",    64'(bus.decPc),        64'h48);
    end_cycle();
    begin_cycle();
    check_eq("bp5_req_valid", 64'(bus.imemReqValid), 64'd1);
    check_eq("bp5_req_addr",  64'(bus.imemReqAddr),  64'h58);
    check_eq("bp5_dec_pc",    64'(bus.decPc),        64'h4C);
    end_cycle();
    begin_cycle();
    check_eq("bp6_req_addr",  64'(bus.imemReqAddr),  64'h5C);
    check_eq("bp6_dec_pc",    64'(bus.decPc),        64'h50);
    end_cycle();
    begin_cycle();
    check_eq("bp7_dec_pc",    64'(bus.decPc),        64'h54);
    end_cycle();

    // Redirect to an unaligned target while the 0x60 fetch is still in flight
    bus.redirect   = 1'b1;
    bus.redirectPc = 32'h0000_0103;
    mem_hold       = 1'b1;
    begin_cycle();
    check_eq("rd0_req_valid", 64'(bus.imemReqValid), 64'd0);
    end_cycle();
    bus.redirect = 1'b0;
    mem_hold     = 1'b0;
    begin_cycle();
    check_eq("rd1_dec_valid", 64'(bus.decValid),     64'd0);
    check_eq("rd1_req_valid", 64'(bus.imemReqValid), 64'd1);
    check_eq("rd1_req_addr",  64'(bus.imemReqAddr),  64'h100);
    end_cycle();
    begin_cycle();
    check_eq("rd2_dec_valid", 64'(bus.decValid),     64'd0);
    check_eq("rd2_req_addr",  64'(bus.imemReqAddr),  64'h104);
    end_cycle();

    // Redirect coinciding with a pop and a response
    bus.redirect   = 1'b1;
    bus.redirectPc = 32'h0000_0200;
    begin_cycle();
    check_eq("rp_dec_valid",  64'(bus.decValid),     64'd1);
    check_eq("rp_dec_pc",     64'(bus.decPc),        64'h100);
    check_eq("rp_dec_instr",  64'(bus.decInstr),     64'(instr_of(32'h100)));
    check_eq("rp_req_valid",  64'(bus.imemReqValid), 64'd0);
    end_cycle();
    bus.redirect = 1'b0;
    begin_cycle();
    check_eq("rp1_dec_valid", 64'(bus.decValid),     64'd0);
    check_eq("rp1_req_addr",  64'(bus.imemReqAddr),  64'h200);
    check_eq("rp1_req_valid", 64'(bus.imemReqValid), 64'd1);
    end_cycle();
    begin_cycle();
    check_eq("rp2_dec_valid", 64'(bus.decValid),     64'd0);
    end_cycle();
    begin_cycle();
    check_eq("rp3_dec_valid", 64'(bus.decValid),     64'd1);
    check_eq("rp3_dec_pc",    64'(bus.decPc),        64'h200);
    end_cycle();

    // Reset mid-stream with the 0x208 response still pending
    resetn   = 1'b0;
    mem_hold = 1'b1;
    begin_cycle();
    check_eq("mr_req_valid",  64'(bus.imemReqValid),  64'd0);
    check_eq("mr_bpu_addr",   64'(bus.bpuAddr),       64'h0);
    check_eq("mr_req_addr",   64'(bus.imemReqAddr),   64'h0);
    check_eq("mr_dec_valid",  64'(bus.decValid),      64'd0);
    check_eq("mr_dec_pc",     64'(bus.decPc),         64'h0);
    check_eq("mr_dec_instr",  64'(bus.decInstr),      64'h0);
    check_eq("mr_dec_target", 64'(bus.decPredTarget), 64'h0);
    end_cycle();
    resetn   = 1'b1;
    mem_hold = 1'b0;
    begin_cycle();
    check_eq("mr1_req_valid", 64'(bus.imemReqValid), 64'd1);
    check_eq("mr1_req_addr",  64'(bus.imemReqAddr),  64'h0);
    check_eq("mr1_dec_valid", 64'(bus.decValid),     64'd0);
    end_cycle();
    begin_cycle();
    check_eq("mr2_dec_valid", 64'(bus.decValid),     64'd0);
    end_cycle();
    begin_cycle();
    check_eq("mr3_dec_valid", 64'(bus.decValid),     64'd1);
    check_eq("mr3_dec_pc",    64'(bus.decPc),        64'h0);
    check_eq("mr3_dec_instr", 64'(bus.decInstr),     64'(instr_of(32'h0)));
    end_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
